// File: rtl/uart_cmd_rcv.sv
// uart_cmd_rcv: reassembles 3-byte command frames from the serial link
// into cmd/data with a ready/clear handshake, abandons partial frames after
// an inter-byte timeout, and serialises single-byte responses back.
module uart_cmd_rcv #(
    parameter int TIMEOUT  = 100000,
    parameter int BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        frm_err,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        resp_sent
);
    typedef enum logic [1:0] {IDLE, GOT1, GOT2} rx_state_t;
    typedef enum logic {RIDLE, RBUSY} rsp_state_t;

    logic       w_rx_rdy, w_tx_done, w_clr_rx_rdy;
    logic [7:0] w_rx_data;
    logic       w_frame_done, w_timeout, w_accept;
    rx_state_t  r_rx_state, w_rx_next;
    rsp_state_t r_rsp_state, w_rsp_next;
    logic [7:0]  r_cmd_hold, r_hi_hold, r_cmd, r_tx_data;
    logic [15:0] r_data;
    logic [16:0] r_timer;
    logic        r_cmd_rdy, r_frm_err, r_trmt, r_resp_sent;

    UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .rx_rdy     (w_rx_rdy),
        .clr_rx_rdy (w_clr_rx_rdy),
        .rx_data    (w_rx_data),
        .trmt       (r_trmt),
        .tx_data    (r_tx_data),
        .tx_done    (w_tx_done)
    );

    // Receive FSM next state: every byte seen is acknowledged in the same cycle.
    always_comb begin
        // NOTE: default every combinational output first so no path infers a latch.
        w_rx_next    = r_rx_state;
        w_clr_rx_rdy = 1'b0;
        w_frame_done = 1'b0;
        w_timeout    = 1'b0;
        case (r_rx_state)
            IDLE: if (w_rx_rdy) begin
                w_clr_rx_rdy = 1'b1;
                w_rx_next    = GOT1;
            end
            GOT1, GOT2: begin
                if (w_rx_rdy) begin
                    // A byte arriving on the timeout cycle wins over the timeout.
                    w_clr_rx_rdy = 1'b1;
                    w_frame_done = (r_rx_state == GOT2);
                    w_rx_next    = (r_rx_state == GOT1) ? GOT2 : IDLE;
                end else if (r_timer == 17'(TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_rx_next = IDLE;
                end
            end
            default: w_rx_next = IDLE;
        endcase
    end

    // Receive state, hold registers, inter-byte timer and frame outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= IDLE;
            r_cmd_hold <= '0;
            r_hi_hold  <= '0;
            r_timer    <= '0;
            r_cmd      <= '0;
            r_data     <= '0;
            r_cmd_rdy  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            r_rx_state <= w_rx_next;
            r_frm_err  <= w_timeout;
            if (r_rx_state == IDLE && w_rx_rdy) r_cmd_hold <= w_rx_data;
            if (r_rx_state == GOT1 && w_rx_rdy) r_hi_hold  <= w_rx_data;
            if (w_timeout) begin
                r_cmd_hold <= '0;
                r_hi_hold  <= '0;
            end
            if (r_rx_state == IDLE || w_clr_rx_rdy || w_timeout) r_timer <= '0;
            else                                                   r_timer <= r_timer + 17'd1;
            if (w_frame_done) begin
                r_cmd  <= r_cmd_hold;
                r_data <= {r_hi_hold, w_rx_data};
            end
            // Completion takes priority over the processor's clear.
            if (w_frame_done)     r_cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
        end
    end

    // Response FSM next state: requests while busy are dropped.
    always_comb begin
        w_rsp_next = r_rsp_state;
        w_accept   = 1'b0;
        case (r_rsp_state)
            RIDLE: if (send_resp) begin
                w_accept   = 1'b1;
                w_rsp_next = RBUSY;
            end
            RBUSY: if (w_tx_done) w_rsp_next = RIDLE;
            default: w_rsp_next = RIDLE;
        endcase
    end

    // Response state, latched byte, one-cycle transmit strobe and done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_state <= RIDLE;
            r_tx_data   <= '0;
            r_trmt      <= 1'b0;
            r_resp_sent <= 1'b0;
        end else begin
            r_rsp_state <= w_rsp_next;
            r_trmt      <= w_accept;
            if (w_accept) begin
                r_tx_data   <= resp;
                r_resp_sent <= 1'b0;
            end else if (r_rsp_state == RBUSY && w_tx_done) begin
                r_resp_sent <= 1'b1;
            end
        end
    end

    assign cmd       = r_cmd;
    assign data      = r_data;
    assign cmd_rdy   = r_cmd_rdy;
    assign frm_err   = r_frm_err;
    assign resp_sent = r_resp_sent;
endmodule

// UART: 8N1 transceiver, BAUD_DIV clocks per bit. rx_rdy is a level cleared
// by clr_rx_rdy; tx_done is a one-cycle pulse at the end of the stop bit.
module UART #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    output logic [7:0] rx_data,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done
);
    logic        r_rx_ff1, r_rx_ff2, r_rx_busy, r_rx_rdy;
    logic [3:0]  r_rx_bits, r_tx_bits;
    logic [15:0] r_rx_baud, r_tx_baud;
    logic [7:0]  r_rx_shift, r_rx_data;
    logic [9:0]  r_tx_shift;
    logic        r_tx_busy, r_tx_done;

    // Receiver: synchronise RX, sample each bit mid-cell starting at the start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ff1   <= 1'b1;
            r_rx_ff2   <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_bits  <= '0;
            r_rx_baud  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_rdy   <= 1'b0;
        end else begin
            r_rx_ff1 <= RX;
            r_rx_ff2 <= r_rx_ff1;
            if (clr_rx_rdy) r_rx_rdy <= 1'b0;
            if (!r_rx_busy) begin
                if (!r_rx_ff2) begin
                    r_rx_busy <= 1'b1;
                    r_rx_bits <= '0;
                    r_rx_baud <= 16'(BAUD_DIV / 2);
                end
            end else if (r_rx_baud == '0) begin
                r_rx_shift <= {r_rx_ff2, r_rx_shift[7:1]};
                r_rx_baud  <= 16'(BAUD_DIV - 1);
                r_rx_bits  <= r_rx_bits + 4'd1;
                if (r_rx_bits == 4'd9) begin
                    // Stop-bit sample: the shifter holds d7..d0.
                    r_rx_busy <= 1'b0;
                    r_rx_data <= r_rx_shift;
                    r_rx_rdy  <= 1'b1;
                end
            end else begin
                r_rx_baud <= r_rx_baud - 16'd1;
            end
        end
    end

    // Transmitter: shift out {stop, data, start} LSB first; line idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift <= '1;
            r_tx_busy  <= 1'b0;
            r_tx_bits  <= '0;
            r_tx_baud  <= '0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (trmt && !r_tx_busy) begin
                r_tx_shift <= {1'b1, tx_data, 1'b0};
                r_tx_busy  <= 1'b1;
                r_tx_bits  <= '0;
                r_tx_baud  <= 16'(BAUD_DIV - 1);
            end else if (r_tx_busy) begin
                if (r_tx_baud == '0) begin
                    r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                    r_tx_baud  <= 16'(BAUD_DIV - 1);
                    r_tx_bits  <= r_tx_bits + 4'd1;
                    if (r_tx_bits == 4'd9) begin
                        r_tx_busy <= 1'b0;
                        r_tx_done <= 1'b1;
                    end
                end else begin
                    r_tx_baud <= r_tx_baud - 16'd1;
                end
            end
        end
    end

    assign TX      = r_tx_shift[0];
    assign rx_rdy  = r_rx_rdy;
    assign rx_data = r_rx_data;
    assign tx_done = r_tx_done;
endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Bench for uart_cmd_rcv: drives frames on RX, decodes TX, and checks both
// against scoreboard queues filled as the stimulus is issued.
module tb_uart_cmd_rcv;
    localparam int BAUD = 16;
    localparam int TO   = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX, cmd_rdy, frm_err, resp_sent;
    logic [7:0]  cmd;
    logic [15:0] data;

    typedef struct {
        logic [7:0]  c;
        logic [15:0] d;
    } frame_t;

    frame_t     sb_frame[$];
    logic [7:0] sb_resp[$];
    int checks = 0;
    int errors = 0;
    int frm_err_cycles = 0;
    int tx_bytes = 0;

    uart_cmd_rcv #(.TIMEOUT(TO), .BAUD_DIV(BAUD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .data        (data),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .frm_err     (frm_err),
        .send_resp   (send_resp),
        .resp        (resp),
        .resp_sent   (resp_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Count every cycle frm_err is high, sampled mid-cycle.
    always @(negedge clk) if (frm_err === 1'b1) frm_err_cycles++;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk) RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = 1'b1;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic pop_frame(input string tag);
        frame_t f;
        check({tag, "_sb"}, 32'(sb_frame.size() != 0), 1);
        if (sb_frame.size() != 0) begin
            f = sb_frame.pop_front();
            check({tag, "_cmd"}, cmd, f.c);
            check({tag, "_data"}, data, f.d);
            check({tag, "_rdy"}, cmd_rdy, 1);
        end
    endtask

    task automatic send_frame(input string tag, input logic [7:0] c, input logic [15:0] d);
        frame_t f;
        f.c = c;
        f.d = d;
        sb_frame.push_back(f);
        send_byte(c);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
        pop_frame(tag);
    endtask

    task automatic pulse_resp(input logic [7:0] b);
        @(negedge clk);
        resp = b;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
    endtask

    task automatic wait_resp_sent(input string tag);
        int n;
        n = 0;
        while (resp_sent !== 1'b1 && n < 14 * BAUD) begin
            @(negedge clk);
            n++;
        end
        check(tag, resp_sent, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd"}, cmd, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_rdy"}, cmd_rdy, 0);
        check({tag, "_ferr"}, frm_err, 0);
        check({tag, "_rsent"}, resp_sent, 0);
        check({tag, "_tx"}, TX, 1);
    endtask

    // TX decoder: pops the expected response for every byte seen on the line.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge TX);
            repeat (BAUD / 2) @(negedge clk);
            check("tx_start", TX, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD) @(negedge clk);
                b[i] = TX;
            end
            repeat (BAUD) @(negedge clk);
            check("tx_stop", TX, 1);
            tx_bytes++;
            check("tx_queue", 32'(sb_resp.size() != 0), 1);
            if (sb_resp.size() != 0) check("tx_byte", b, sb_resp.pop_front());
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit seen_low, seen_high;

        // Reset values.
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic frame.
        send_frame("f1", 8'h05, 16'hABCD);
        check("f1_noferr", frm_err_cycles, 0);

        // Clear handshake: values held, ready drops next cycle.
        @(negedge clk) clr_cmd_rdy = 1'b1;
        @(negedge clk) clr_cmd_rdy = 1'b0;
        check("clr_rdy", cmd_rdy, 0);
        check("clr_cmd", cmd, 8'h05);
        check("clr_data", data, 16'hABCD);

        // Partial frame then silence: one frm_err pulse near TIMEOUT clocks.
        send_byte(8'h02);
        send_byte(8'h11);
        n = 0;
        while (frm_err !== 1'b1 && n < 2 * TO) begin
            @(negedge clk);
            n++;
        end
        check("to_lat", 32'(n >= TO - 20 && n <= TO + 4), 1);
        repeat (TO) @(negedge clk);
        check("to_pulses", frm_err_cycles, 1);
        check("to_rdy", cmd_rdy, 0);
        check("to_cmd", cmd, 8'h05);
        send_frame("f2", 8'h03, 16'h007F);
        check("f2_ferr", frm_err_cycles, 1);

        // Back-to-back frames without clearing.
        send_frame("bb1", 8'h01, 16'h1234);
        send_frame("bb2", 8'h04, 16'h5678);

        // Clear held high across the third byte: completion must win.
        begin
            frame_t f;
            f.c = 8'h06;
            f.d = 16'h9ABC;
            sb_frame.push_back(f);
        end
        send_byte(8'h06);
        send_byte(8'h9A);
        seen_low = 1'b0;
        seen_high = 1'b0;
        fork
            send_byte(8'hBC);
            begin
                clr_cmd_rdy = 1'b1;
                n = 0;
                while (!seen_high && n < 12 * BAUD) begin
                    @(negedge clk);
                    n++;
                    if (cmd_rdy === 1'b0) seen_low = 1'b1;
                    else if (seen_low && cmd_rdy === 1'b1) seen_high = 1'b1;
                end
                clr_cmd_rdy = 1'b0;
            end
        join
        check("coinc_seen", 32'({seen_low, seen_high}), 32'b11);
        @(negedge clk);
        pop_frame("coinc");

        // Response 0xA5; a second request mid-transmission is ignored.
        sb_resp.push_back(8'hA5);
        pulse_resp(8'hA5);
        repeat (5 * BAUD) @(negedge clk);
        pulse_resp(8'h5A);
        wait_resp_sent("r1_sent");

        // Second response concurrent with a frame on RX.
        sb_resp.push_back(8'h3C);
        pulse_resp(8'h3C);
        check("r2_fall", resp_sent, 0);
        send_frame("conc", 8'h07, 16'hBEEF);
        wait_resp_sent("r2_sent");
        repeat (3 * BAUD) @(negedge clk);
        check("tx_left", sb_resp.size(), 0);
        check("tx_count", tx_bytes, 2);

        // Reset after the second byte of a frame.
        send_byte(8'h08);
        send_byte(8'h22);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("mrst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame("post", 8'h09, 16'h3344);
        check("post_ferr", frm_err_cycles, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
